// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a ready handshake,
// holds them in the IR and selects the next PC from the Jump/Branch decisions.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] count_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump outranks a taken branch; an untaken branch falls through.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (branch && zero)
      next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state   <= ISSUE;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) begin
            count_q <= count_q + 32'd1;
            pc_q    <= next_pc;
            state   <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign inst_count  = count_q;
  assign op          = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign shamt       = instr_q[10:6];
  assign func        = instr_q[5:0];
  assign imm16       = instr_q[15:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected fetch addresses and IR words
// are queued as stimulus is driven and popped as the DUT fetches/issues.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready, stall, branch, zero, jump, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, inst_count;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_count;
  logic [5:0]  w_op, w_func;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] cur_pc, cur_instr;
  int unsigned exp_count = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch(branch), .zero(zero), .jump(jump), .instr_valid(instr_valid),
    .instr(instr), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .func(func), .imm16(imm16), .pc(pc), .pc_plus4(pc_plus4),
    .inst_count(inst_count)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(32'h2408_0001), .stall(1'b0),
    .branch(1'b0), .zero(1'b0), .jump(1'b0), .instr_valid(w_valid),
    .instr(w_instr), .op(w_op), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .shamt(w_shamt), .func(w_func), .imm16(w_imm), .pc(w_pc),
    .pc_plus4(w_pc4), .inst_count(w_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h1000_0003;  // beq +3
      32'h0000_0020: return 32'h1000_FFFE;  // beq -2
      32'h0000_0024: return 32'h0810_0000;  // j 0x0100000
      32'h0040_0000: return 32'h0810_0010;  // j 0x0100010
      default:       return 32'h2408_0000 | {16'h0, a[15:0]};  // addiu
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ir,
                                             input logic br, input logic z, input logic jp);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = p + 32'd4;
    off = {{14{ir[15]}}, ir[15:0], 2'b00};
    if (jp)           return {p4[31:28], ir[25:0], 2'b00};
    else if (br && z) return p4 + off;
    else              return p4;
  endfunction

  task automatic fetch_one(input int unsigned waits);
    int unsigned guard = 0;
    while (!imem_req && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check_eq("req_seen", {31'b0, imem_req}, 32'd1);
    if (exp_addr_q.size() == 0) begin
      check_eq("addr_q_empty", 32'd0, 32'd1);
      return;
    end
    cur_pc = exp_addr_q.pop_front();
    check_eq("imem_addr", imem_addr, cur_pc);
    check_eq("fetch_valid", {31'b0, instr_valid}, 32'd0);
    for (int unsigned w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      check_eq("wait_addr", imem_addr, cur_pc);
      check_eq("wait_req", {31'b0, imem_req}, 32'd1);
      check_eq("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = mem_word(cur_pc);
    exp_instr_q.push_back(imem_rdata);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    cur_instr  = exp_instr_q.pop_front();
    check_eq("issue_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("issue_req", {31'b0, imem_req}, 32'd0);
    check_eq("instr", instr, cur_instr);
    check_eq("op", {26'b0, op}, {26'b0, cur_instr[31:26]});
    check_eq("imm16", {16'b0, imm16}, {16'b0, cur_instr[15:0]});
    check_eq("pc_plus4", pc_plus4, cur_pc + 32'd4);
  endtask

  task automatic retire(input int unsigned stalls, input logic br, input logic z, input logic jp);
    for (int unsigned s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      jump       = s[0];
      branch     = 1'b1;
      zero       = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = 32'hFFFF_0000 | s;
      @(negedge clk);
      check_eq("stall_valid", {31'b0, instr_valid}, 32'd1);
      check_eq("stall_pc", pc, cur_pc);
      check_eq("stall_instr", instr, cur_instr);
      check_eq("stall_count", inst_count, exp_count);
      check_eq("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall      = 1'b0;
    imem_ready = 1'b0;
    branch     = br;
    zero       = z;
    jump       = jp;
    exp_addr_q.push_back(model_next(cur_pc, cur_instr, br, z, jp));
    exp_count++;
    @(negedge clk);
    branch = 1'b0;
    zero   = 1'b0;
    jump   = 1'b0;
    check_eq("inst_count", inst_count, exp_count);
    check_eq("retire_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("retire_req", {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge rst);
    @(negedge clk);
    check_eq("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check_eq("wrap_req0", {31'b0, w_req}, 32'd1);
    @(negedge clk);
    check_eq("wrap_valid", {31'b0, w_valid}, 32'd1);
    check_eq("wrap_pc4", w_pc4, 32'h0000_0000);
    @(negedge clk);
    check_eq("wrap_addr1", w_addr, 32'h0000_0000);
    check_eq("wrap_count", w_count, 32'd1);
  end

  initial begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_count", inst_count, 32'h0);
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    #3 rst = 1'b0;
    #1 check_eq("idle_req", {31'b0, imem_req}, 32'd0);
    exp_addr_q.push_back(32'h0);
    @(negedge clk);

    fetch_one(0); retire(0, 1'b0, 1'b0, 1'b0);
    fetch_one(0); retire(0, 1'b0, 1'b0, 1'b0);
    fetch_one(3); retire(4, 1'b0, 1'b0, 1'b0);
    check_eq("count_after3", inst_count, 32'd3);
    fetch_one(0); retire(0, 1'b0, 1'b0, 1'b0);
    fetch_one(0); retire(0, 1'b1, 1'b1, 1'b0);
    check_eq("br_fwd_tgt", imem_addr, 32'h0000_0020);
    fetch_one(0); retire(0, 1'b1, 1'b1, 1'b0);
    check_eq("br_back_tgt", imem_addr, 32'h0000_001C);
    fetch_one(1); retire(0, 1'b0, 1'b0, 1'b0);
    fetch_one(0); retire(2, 1'b1, 1'b0, 1'b0);
    check_eq("br_nottaken", imem_addr, 32'h0000_0024);
    fetch_one(0); retire(0, 1'b0, 1'b0, 1'b1);
    check_eq("jump_tgt0", imem_addr, 32'h0040_0000);
    fetch_one(0); retire(0, 1'b1, 1'b1, 1'b1);
    check_eq("jump_wins", imem_addr, 32'h0040_0040);
    fetch_one(0);

    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("arst_req", {31'b0, imem_req}, 32'd0);
    check_eq("arst_pc", pc, 32'h0);
    check_eq("arst_count", inst_count, 32'h0);
    rst = 1'b0;
    #1 check_eq("arst_idle_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    exp_addr_q.delete();
    exp_addr_q.push_back(32'h0);
    exp_count = 0;
    fetch_one(0); retire(0, 1'b0, 1'b0, 1'b0);
    check_eq("restart_addr", imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
